// File: rtl/regfile_dbg_pkg.sv
// Shared types and sizes for the register-file debug port.
package regfile_dbg_pkg;

    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned DATA_W    = 32;

    typedef enum logic [1:0] {
        OpRead    = 2'b00,
        OpWrite   = 2'b01,
        OpDump    = 2'b10,
        OpIllegal = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAccess = 2'b01,
        StResp   = 2'b10
    } state_e;

endpackage

// File: rtl/regfile_dbg_mux.sv
// Steers register-file ports between the core and the debug engine.
module regfile_dbg_mux
    import regfile_dbg_pkg::*;
(
    input  logic              dbg_sel_i,
    input  logic              wrt_kill_i,
    input  logic [ADDR_W-1:0] core_rd_addr1_i,
    input  logic [ADDR_W-1:0] core_rd_addr2_i,
    input  logic [ADDR_W-1:0] core_wrt_addr_i,
    input  logic              core_wrt_en_i,
    input  logic [DATA_W-1:0] core_wrt_data_i,
    input  logic [ADDR_W-1:0] dbg_rd_addr1_i,
    input  logic [ADDR_W-1:0] dbg_wrt_addr_i,
    input  logic              dbg_wrt_en_i,
    input  logic [DATA_W-1:0] dbg_wrt_data_i,
    output logic [ADDR_W-1:0] rg_rd_addr1_o,
    output logic [ADDR_W-1:0] rg_rd_addr2_o,
    output logic [ADDR_W-1:0] rg_wrt_addr_o,
    output logic              rg_wrt_en_o,
    output logic [DATA_W-1:0] rg_wrt_data_o
);

    always_comb begin
        rg_rd_addr2_o = core_rd_addr2_i;
        if (dbg_sel_i) begin
            rg_rd_addr1_o = dbg_rd_addr1_i;
            rg_wrt_addr_o = dbg_wrt_addr_i;
            rg_wrt_en_o   = dbg_wrt_en_i;
            rg_wrt_data_o = dbg_wrt_data_i;
        end else begin
            rg_rd_addr1_o = core_rd_addr1_i;
            rg_wrt_addr_o = core_wrt_addr_i;
            rg_wrt_en_o   = core_wrt_en_i;
            rg_wrt_data_o = core_wrt_data_i;
        end
        // Reset must never let a half-finished command or a core write reach the file.
        if (wrt_kill_i) begin
            rg_wrt_en_o = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_dbg_port.sv
// Debug command/response engine that borrows the register file while stalling the core.
module regfile_dbg_port
    import regfile_dbg_pkg::*;
#(
    parameter bit PROTECT_X0 = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic              core_stall,
    input  logic [ADDR_W-1:0] core_rd_addr1,
    input  logic [ADDR_W-1:0] core_rd_addr2,
    input  logic [ADDR_W-1:0] core_wrt_addr,
    input  logic              core_wrt_en,
    input  logic [DATA_W-1:0] core_wrt_data,
    output logic [ADDR_W-1:0] rg_rd_addr1,
    output logic [ADDR_W-1:0] rg_rd_addr2,
    output logic [ADDR_W-1:0] rg_wrt_addr,
    output logic              rg_wrt_en,
    output logic [DATA_W-1:0] rg_wrt_data,
    input  logic [DATA_W-1:0] rg_rd_data1
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(REG_COUNT - 1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic              rsp_last_q, rsp_last_d;
    logic              rsp_err_q, rsp_err_d;
    logic              dbg_wrt_en;
    logic [ADDR_W-1:0] dbg_rd_addr1;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        idx_d        = idx_q;
        rsp_data_d   = rsp_data_q;
        rsp_addr_d   = rsp_addr_q;
        rsp_last_d   = rsp_last_q;
        rsp_err_d    = rsp_err_q;
        cmd_ready    = 1'b0;
        dbg_wrt_en   = 1'b0;
        dbg_rd_addr1 = (op_q == OpDump) ? idx_q : addr_q;

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d    = op_e'(cmd_op);
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    idx_d   = '0;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                state_d    = StResp;
                rsp_addr_d = addr_q;
                rsp_last_d = 1'b1;
                rsp_err_d  = 1'b0;
                unique case (op_q)
                    OpRead:  rsp_data_d = rg_rd_data1;
                    OpWrite: begin
                        dbg_wrt_en = !(PROTECT_X0 && (addr_q == '0));
                        rsp_data_d = wdata_q;
                    end
                    OpDump: begin
                        rsp_data_d = rg_rd_data1;
                        rsp_addr_d = idx_q;
                        rsp_last_d = (idx_q == LastIdx);
                    end
                    default: begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                    end
                endcase
            end
            StResp: begin
                if (rsp_ready) begin
                    if (rsp_last_q) begin
                        state_d = StIdle;
                    end else begin
                        // rsp_last is set at LastIdx, so the index never wraps.
                        idx_d   = idx_q + 1'b1;
                        state_d = StAccess;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            op_q       <= OpRead;
            addr_q     <= '0;
            wdata_q    <= '0;
            idx_q      <= '0;
            rsp_data_q <= '0;
            rsp_addr_q <= '0;
            rsp_last_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            idx_q      <= idx_d;
            rsp_data_q <= rsp_data_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_last_q <= rsp_last_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rsp_valid  = (state_q == StResp);
    assign core_stall = (state_q != StIdle);
    assign rsp_data   = rsp_data_q;
    assign rsp_addr   = rsp_addr_q;
    assign rsp_last   = rsp_last_q;
    assign rsp_err    = rsp_err_q;

    regfile_dbg_mux u_mux (
        .dbg_sel_i       (core_stall),
        .wrt_kill_i      (reset),
        .core_rd_addr1_i (core_rd_addr1),
        .core_rd_addr2_i (core_rd_addr2),
        .core_wrt_addr_i (core_wrt_addr),
        .core_wrt_en_i   (core_wrt_en),
        .core_wrt_data_i (core_wrt_data),
        .dbg_rd_addr1_i  (dbg_rd_addr1),
        .dbg_wrt_addr_i  (addr_q),
        .dbg_wrt_en_i    (dbg_wrt_en),
        .dbg_wrt_data_i  (wdata_q),
        .rg_rd_addr1_o   (rg_rd_addr1),
        .rg_rd_addr2_o   (rg_rd_addr2),
        .rg_wrt_addr_o   (rg_wrt_addr),
        .rg_wrt_en_o     (rg_wrt_en),
        .rg_wrt_data_o   (rg_wrt_data)
    );

endmodule

// File: tb/tb_regfile_dbg_port.sv
// Self-checking bench: register-file model, response-queue reference and directed scenarios.
module tb_regfile_dbg_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [4:0]  rsp_addr;
    logic [31:0] rsp_data;
    logic        rsp_last, rsp_err, core_stall;
    logic [4:0]  core_rd_addr1, core_rd_addr2, core_wrt_addr;
    logic        core_wrt_en;
    logic [31:0] core_wrt_data;
    logic [4:0]  rg_rd_addr1, rg_rd_addr2, rg_wrt_addr;
    logic        rg_wrt_en;
    logic [31:0] rg_wrt_data, rg_rd_data1;

    regfile_dbg_port dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_addr      (rsp_addr),
        .rsp_data      (rsp_data),
        .rsp_last      (rsp_last),
        .rsp_err       (rsp_err),
        .core_stall    (core_stall),
        .core_rd_addr1 (core_rd_addr1),
        .core_rd_addr2 (core_rd_addr2),
        .core_wrt_addr (core_wrt_addr),
        .core_wrt_en   (core_wrt_en),
        .core_wrt_data (core_wrt_data),
        .rg_rd_addr1   (rg_rd_addr1),
        .rg_rd_addr2   (rg_rd_addr2),
        .rg_wrt_addr   (rg_wrt_addr),
        .rg_wrt_en     (rg_wrt_en),
        .rg_wrt_data   (rg_wrt_data),
        .rg_rd_data1   (rg_rd_data1)
    );

    always #5 clk = ~clk;

    // Register file the DUT drives.
    logic [31:0] rf [32] = '{default: 32'h0};
    always @(posedge clk) if (rg_wrt_en) rf[rg_wrt_addr] <= rg_wrt_data;
    assign rg_rd_data1 = rf[rg_rd_addr1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: file contents plus the list of responses a command must produce.
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] ref_rf [32] = '{default: 32'h0};
    bit          m_busy = 0, m_valid = 0, m_first = 0;
    logic [1:0]  m_op;
    logic [4:0]  m_addr;
    logic [31:0] m_wdata;

    initial begin : model_and_compare
        bit exp_wen;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_busy = 0; m_valid = 0; m_first = 0;
                exp_q.delete();
            end else if (!m_busy) begin
                if (core_wrt_en) ref_rf[core_wrt_addr] = core_wrt_data;
                if (cmd_valid) begin
                    m_busy = 1; m_first = 1; m_valid = 0;
                    m_op = cmd_op; m_addr = cmd_addr; m_wdata = cmd_wdata;
                    case (cmd_op)
                        2'b00: exp_q.push_back('{addr: cmd_addr, data: ref_rf[cmd_addr],
                                                 last: 1'b1, err: 1'b0});
                        2'b01: exp_q.push_back('{addr: cmd_addr, data: cmd_wdata,
                                                 last: 1'b1, err: 1'b0});
                        2'b10: for (int i = 0; i < 32; i++)
                            exp_q.push_back('{addr: 5'(i), data: ref_rf[i],
                                              last: (i == 31), err: 1'b0});
                        default: exp_q.push_back('{addr: cmd_addr, data: 32'h0,
                                                   last: 1'b1, err: 1'b1});
                    endcase
                end
            end else if (m_first) begin
                if (m_op == 2'b01 && m_addr != 5'd0) ref_rf[m_addr] = m_wdata;
                m_first = 0; m_valid = 1;
            end else if (m_valid && rsp_ready) begin
                void'(exp_q.pop_front());
                m_valid = 0;
                if (exp_q.size() == 0) m_busy = 0;
                else m_first = 1;
            end

            @(negedge clk);
            exp_wen = reset ? 1'b0
                    : (m_busy ? (m_first && m_op == 2'b01 && m_addr != 5'd0) : core_wrt_en);
            chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
            chk("core_stall", 32'(core_stall), 32'(m_busy));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("rg_wrt_en", 32'(rg_wrt_en), 32'(exp_wen));
            chk("rg_rd_addr2", 32'(rg_rd_addr2), 32'(core_rd_addr2));
            if (!m_busy) begin
                chk("pass_rd_addr1", 32'(rg_rd_addr1), 32'(core_rd_addr1));
                chk("pass_wrt_addr", 32'(rg_wrt_addr), 32'(core_wrt_addr));
                chk("pass_wrt_data", rg_wrt_data, core_wrt_data);
            end else if (exp_wen) begin
                chk("dbg_wrt_addr", 32'(rg_wrt_addr), 32'(m_addr));
                chk("dbg_wrt_data", rg_wrt_data, m_wdata);
            end
            if (m_busy && m_first && m_op == 2'b00)
                chk("read_rd_addr1", 32'(rg_rd_addr1), 32'(m_addr));
            if (m_busy && m_first && m_op == 2'b10)
                chk("dump_rd_addr1", 32'(rg_rd_addr1), 32'(32 - exp_q.size()));
            if (m_valid && exp_q.size() > 0) begin
                chk("rsp_data", rsp_data, exp_q[0].data);
                chk("rsp_last", 32'(rsp_last), 32'(exp_q[0].last));
                chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
                if (!exp_q[0].err) chk("rsp_addr", 32'(rsp_addr), 32'(exp_q[0].addr));
            end
        end
    end

    // Stimulus helpers
    bit          rand_core = 0, rand_ready = 0, walk_core = 0;
    logic [4:0]  g_addr [32];
    logic [31:0] g_data [32];
    logic        g_last [32];
    logic        g_err  [32];
    int          first_cyc, last_cyc, acc;

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_core) begin
            core_rd_addr1 = 5'($urandom);
            core_rd_addr2 = 5'($urandom);
            core_wrt_addr = 5'($urandom);
            core_wrt_en   = ($urandom_range(0, 3) == 0);
            core_wrt_data = $urandom;
        end
        if (walk_core) core_wrt_data = core_wrt_data + 32'd1;
        if (rand_ready) rsp_ready = 1'($urandom);
    endtask

    task automatic send(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] wd);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
        acc = cyc;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic collect(input int n, input bit toggle);
        int got = 0;
        int guard = 0;
        first_cyc = -1; last_cyc = -1;
        rsp_ready = toggle ? 1'b0 : 1'b1;
        while (got < n && guard < 8 * n + 20) begin
            @(negedge clk);
            if (rsp_valid && first_cyc < 0) first_cyc = cyc;
            if (rsp_valid && rsp_ready) begin
                g_addr[got] = rsp_addr; g_data[got] = rsp_data;
                g_last[got] = rsp_last; g_err[got] = rsp_err;
                got++;
                last_cyc = cyc;
            end
            if (got < n) begin
                step();
                if (toggle) rsp_ready = !rsp_ready;
                guard++;
            end
        end
        chk("rsp_count", 32'(got), 32'(n));
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 5'd0; cmd_wdata = 32'h0;
        rsp_ready = 1'b0; core_rd_addr1 = 5'd0; core_rd_addr2 = 5'd0; core_wrt_addr = 5'd0;
        core_wrt_en = 1'b0; core_wrt_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_core_stall", 32'(core_stall), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'h0);
        chk("reset_rsp_addr", 32'(rsp_addr), 32'd0);
        chk("reset_rsp_last", 32'(rsp_last), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        step();
        reset = 1'b0;
        step();

        // Write then read x5
        send(2'b01, 5'd5, 32'hDEADBEEF);
        collect(1, 0);
        chk("wr5_data", g_data[0], 32'hDEADBEEF);
        chk("wr5_last", 32'(g_last[0]), 32'd1);
        chk("wr5_latency", 32'(first_cyc - acc), 32'd2);
        step();
        send(2'b00, 5'd5, 32'h0);
        collect(1, 0);
        chk("rd5_data", g_data[0], 32'hDEADBEEF);
        chk("rd5_latency", 32'(first_cyc - acc), 32'd2);
        step();

        // Protected x0
        send(2'b01, 5'd0, 32'h12345678);
        collect(1, 0);
        chk("wr0_data", g_data[0], 32'h12345678);
        step();
        send(2'b00, 5'd0, 32'h0);
        collect(1, 0);
        chk("rd0_data", g_data[0], 32'h0);
        chk("rf_x0", rf[0], 32'h0);
        step();

        // Illegal op
        send(2'b11, 5'd3, 32'hFFFF_FFFF);
        collect(1, 0);
        chk("ill_err", 32'(g_err[0]), 32'd1);
        chk("ill_data", g_data[0], 32'h0);
        chk("ill_last", 32'(g_last[0]), 32'd1);
        step();

        // Core write to x7 held through a debug read: only the accept-cycle data lands
        core_wrt_addr = 5'd7; core_wrt_data = 32'h0000_7000; core_wrt_en = 1'b1; walk_core = 1;
        send(2'b00, 5'd7, 32'h0);
        collect(1, 0);
        chk("rd7_data", g_data[0], 32'h0000_7000);
        step();
        core_wrt_en = 1'b0; walk_core = 0;
        step();
        chk("rf_x7", rf[7], 32'h0000_7000);

        // Preload xi = i*3 through the core port
        for (int i = 0; i < 32; i++) begin
            core_wrt_en = 1'b1; core_wrt_addr = 5'(i); core_wrt_data = 32'(i * 3);
            step();
        end
        core_wrt_en = 1'b0;
        step();

        send(2'b10, 5'd0, 32'h0);
        collect(32, 1);
        for (int i = 0; i < 32; i++) begin
            chk("dump_addr", 32'(g_addr[i]), 32'(i));
            chk("dump_data", g_data[i], 32'(i * 3));
            chk("dump_last", 32'(g_last[i]), 32'(i == 31));
        end
        step();
        send(2'b10, 5'd0, 32'h0);
        collect(32, 0);
        chk("dump_span", 32'(last_cyc - acc), 32'd64);
        step();

        // Reset during the access cycle of a write to x9
        send(2'b01, 5'd9, 32'hA5A5A5A5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_idle", 32'(cmd_ready), 32'd1);
        chk("abort_stall", 32'(core_stall), 32'd0);
        chk("abort_x9", rf[9], 32'd27);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Randomized traffic against the reference
        rand_core = 1; rand_ready = 1;
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 15);
            cmd_valid = 1'($urandom);
            cmd_op    = (r < 1) ? 2'b10 : (r < 7) ? 2'b00 : (r < 13) ? 2'b01 : 2'b11;
            cmd_addr  = 5'($urandom);
            cmd_wdata = $urandom;
            reset     = ($urandom_range(0, 299) == 0);
            step();
        end
        rand_core = 0; rand_ready = 0;
        cmd_valid = 1'b0; reset = 1'b0; core_wrt_en = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 200 && m_busy; i++) step();
        chk("drain", 32'(m_busy), 32'd0);
        step();
        for (int i = 0; i < 32; i++) chk("final_rf", rf[i], ref_rf[i]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_dbg_port.md
REGFILE_DBG_PORT -- requirements
Module: regfile_dbg_port

Interface
REQ-001 The block SHALL have one clock, clk; reset SHALL be synchronous and active-high, named reset.
REQ-002 The block SHALL have parameter PROTECT_X0, default 1: debug writes to address 0 are dropped but still acknowledged.
REQ-003 Ports SHALL be, as name direction width meaning:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_op  in  2  00 read, 01 write, 10 dump-all, 11 illegal
- cmd_addr  in  5  register index
- cmd_wdata  in  32  write data
- rsp_valid  out  1  response offered
- rsp_ready  in  1  response consumed when both high
- rsp_addr  out  5  register index of response
- rsp_data  out  32  read data, or written data for writes
- rsp_last  out  1  final response of the command
- rsp_err  out  1  illegal op
- core_stall  out  1  core must hold PC and state
- core_rd_addr1, core_rd_addr2, core_wrt_addr  in  5 each  core register-file requests
- core_wrt_en  in  1  core write enable
- core_wrt_data  in  32  core write data
- rg_rd_addr1, rg_rd_addr2, rg_wrt_addr  out  5 each  to register file
- rg_wrt_en  out  1  to register file
- rg_wrt_data  out  32  to register file
- rg_rd_data1  in  32  register-file read port 1 data (combinational)

Function
REQ-004 States SHALL be IDLE, ACCESS, RESP; core_stall SHALL equal (state != IDLE), decoded from the registered state.
REQ-005 In IDLE: cmd_ready=1, all rg_* outputs SHALL equal the matching core_* inputs, and rsp_valid=0.
REQ-006 On the cmd_valid&cmd_ready cycle, the block SHALL capture op, addr, and wdata. The core write in that cycle SHALL pass through. The next state SHALL be ACCESS, with dump index cleared to 0.
REQ-007 Outside IDLE: cmd_ready=0; rg_rd_addr2=core_rd_addr2; rg_rd_addr1 and rg_wrt_addr driven by the block; core_wrt_en SHALL be blocked.
REQ-008 ACCESS read: rg_rd_addr1=captured addr; rg_rd_data1 SHALL be registered into rsp_data; next state RESP.
REQ-009 ACCESS write: rg_wrt_en=1 for exactly that cycle, with rg_wrt_addr and rg_wrt_data from the capture. With PROTECT_X0=1 and addr=0, rg_wrt_en SHALL stay 0. rsp_data SHALL be the captured wdata; next state RESP.
REQ-010 ACCESS dump: rg_rd_addr1=dump index; registered data SHALL go to rsp_data and the index to rsp_addr; next state RESP.
REQ-011 ACCESS illegal op: no register access; rsp_data=0, rsp_err=1; next state RESP.
REQ-012 RESP: rsp_valid=1, with rsp_data/addr/last/err held stable until rsp_ready.
REQ-013 On a handshake in RESP with rsp_last=1, the next state SHALL be IDLE. Otherwise (dump, index<31) the index SHALL increment and the next state SHALL be ACCESS.
REQ-014 rsp_last SHALL be 1 for read, write, and illegal ops, and for dump only at index 31; the index SHALL never wrap past 31.
REQ-015 Latency: from an accept at cycle N, the first rsp_valid SHALL be at N+2; the dump SHALL take 64 cycles minimum for 32 responses with rsp_ready held high.
REQ-016 After the final handshake, core_stall SHALL drop and cmd_ready SHALL rise in the next cycle; back-to-back commands SHALL be legal.

Reset
REQ-017 While reset=1: state=IDLE, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_last=0, rsp_err=0, dump index=0, core_stall=0, and rg_wrt_en forced 0 combinationally.
REQ-018 Reset during ACCESS or RESP SHALL abort the command with no write and no further response.

Structure
REQ-019 The shared package regfile_dbg_pkg SHALL hold the op encodings, the state enum, and REG_COUNT=32, ADDR_W=5, DATA_W=32.
REQ-020 The combinational port mux SHALL be one sub-module, regfile_dbg_mux; the FSM, capture registers, and counter SHALL live in regfile_dbg_port.

Verification
REQ-021 Write x5=0xDEADBEEF, then read x5 -> write response rsp_data=0xDEADBEEF with rsp_last=1; read response rsp_data=0xDEADBEEF at N+2.
REQ-022 PROTECT_X0=1, write x0=0x12345678 -> rg_wrt_en never high; response issued; a subsequent read x0 returns 0.
REQ-023 Preload xi=i*3, dump with rsp_ready toggling every other cycle -> 32 responses in order, rsp_addr 0..31, data i*3, rsp_last only at 31, outputs stable while stalled.
REQ-024 core_wrt_en=1 to x7 held throughout a debug read -> core write lands only in the accept cycle; blocked while core_stall=1.
REQ-025 Assert reset in the ACCESS cycle of a write to x9=0xA5A5A5A5 -> x9 unchanged, rsp_valid stays 0, state IDLE next cycle.
REQ-026 cmd_op=11 -> a single response with rsp_err=1, rsp_data=0, rsp_last=1, and no rg_wrt_en.
